ahb_slave_mem_ws: RTL



---
 rtl/ahb_slave_mem_ws.sv | 90 +++++++++
 1 files changed

// File: rtl/ahb_slave_mem_ws.sv
// ahb_slave_mem_ws: AHB-Lite leaf slave memory with programmable wait states,
// two-cycle ERROR responses, alignment/range checking and per-lane byte writes.
module ahb_slave_mem_ws #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(MEM_DEPTH * 4);

    typedef enum logic [1:0] {IDLE_ST, WAIT_ST, ERR1_ST, ERR2_ST} state_t;

    state_t                r_state, w_next;
    logic [3:0]            r_cnt;
    logic                  r_pend;
    logic                  r_write;
    logic [1:0]            r_size;
    logic [IW+1:0]         r_off;
    logic [31:0]           r_mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] w_off;
    logic                  w_err, w_acc, w_pend;
    logic [3:0]            w_be;

    // unsigned offset: addresses below the base wrap high and fail the range test
    assign w_off  = HADDR - BASE_ADDR;
    assign w_err  = HSIZE > 3'd2 || (HSIZE == 3'd1 && HADDR[0]) ||
                    (HSIZE == 3'd2 && HADDR[1:0] != 2'b00) || w_off >= SPAN;
    assign w_acc  = HSEL && HREADY && (HTRANS == 2'b10 || HTRANS == 2'b11) &&
                    (r_state == IDLE_ST || r_state == ERR2_ST);
    assign w_pend = (w_acc && !w_err && WAIT_STATES == 0) || (r_state == WAIT_ST && r_cnt == 4'd0);
    assign w_be   = r_size == 2'd0 ? 4'b0001 << r_off[1:0] :
                    r_size == 2'd1 ? (r_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= IDLE_ST;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_acc ? 4'(WAIT_STATES - 1) : r_state == WAIT_ST ? r_cnt - 4'd1 : r_cnt;
            r_pend  <= w_pend;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE_ST, ERR2_ST: w_next = !w_acc ? IDLE_ST : w_err ? ERR1_ST :
                                       WAIT_STATES > 0 ? WAIT_ST : IDLE_ST;
            WAIT_ST:          w_next = r_cnt == 4'd0 ? IDLE_ST : WAIT_ST;
            default:          w_next = ERR2_ST;
        endcase
    end

    always_comb begin
        HREADYOUT = r_state == IDLE_ST || r_state == ERR2_ST;
        HRESP     = r_state == ERR1_ST || r_state == ERR2_ST;
        HRDATA    = r_pend && !r_write ? r_mem[r_off[IW+1:2]] : '0;
    end

    always_ff @(posedge HCLK) begin
        if (w_acc) begin
            r_off   <= w_off[IW+1:0];
            r_write <= HWRITE;
            r_size  <= HSIZE[1:0];
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESET && r_pend && r_write)
            for (int b = 0; b < 4; b++)
                if (w_be[b]) r_mem[r_off[IW+1:2]][8*b +: 8] <= HWDATA[8*b +: 8];
    end
endmodule
